// File: rtl/mpmc10_resp_fifo128_wb.sv
// Response-return buffer for one mpmc10 port.
// Queues 128-bit read responses in order and hands them to the initiator
// over a valid/ready handshake. Pushes that arrive while the queue is full
// and not being drained are dropped and latch a sticky overflow flag.

package mpmc10_resp_pkg;
  typedef struct packed {
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic         ack;
    logic         err;
    logic         rty;
    logic [31:0]  adr;
    logic [127:0] dat;
  } wb_read_response128_t;
endpackage

module mpmc10_resp_fifo128_wb
  import mpmc10_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  wb_read_response128_t       i,
  output wb_read_response128_t       o,
  input  logic                       rdy,
  output logic                       afull,
  output logic                       empty,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_read_response128_t mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr;

  assign push  = i.ack | i.err | i.rty;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign afull = (cnt >= CW'(AFULL));
  assign pop   = rdy & ~empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign wr    = push & (~full | pop);

  // Entry storage; contents need no reset because cnt guards every read.
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= i;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      case ({wr, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push & full & ~pop) ovf <= 1'b1;
    end
  end

  // Head of queue, with the handshake flags gated off while empty.
  always_comb begin
    o     = mem[rp];
    o.ack = mem[rp].ack & ~empty;
    o.err = mem[rp].err & ~empty;
    o.rty = mem[rp].rty & ~empty;
  end

endmodule

// File: tb/tb_mpmc10_resp_fifo128_wb.sv
// Bench for mpmc10_resp_fifo128_wb: directed scenarios followed by random
// traffic, all compared against a queue-based model of the buffer.

module tb_mpmc10_resp_fifo128_wb;
  import mpmc10_resp_pkg::*;

  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  wb_read_response128_t  i;
  wb_read_response128_t  o;
  logic                  rdy;
  logic                  afull;
  logic                  empty;
  logic                  ovf;
  logic [$clog2(DEPTH):0] cnt;

  int total = 0;
  int bad   = 0;

  wb_read_response128_t mq[$];
  bit                   ovf_m;

  mpmc10_resp_fifo128_wb #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk   (clk),
    .rst   (rst),
    .i     (i),
    .o     (o),
    .rdy   (rdy),
    .afull (afull),
    .empty (empty),
    .ovf   (ovf),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("cnt",   128'(cnt),   128'(mq.size()));
    chk("empty", 128'(empty), 128'(mq.size() == 0));
    chk("afull", 128'(afull), 128'(mq.size() >= AFULL));
    chk("ovf",   128'(ovf),   128'(ovf_m));
    if (mq.size() > 0) begin
      chk("ack", 128'(o.ack), 128'(mq[0].ack));
      chk("err", 128'(o.err), 128'(mq[0].err));
      chk("rty", 128'(o.rty), 128'(mq[0].rty));
      chk("dat", o.dat,       mq[0].dat);
      chk("adr", 128'(o.adr), 128'(mq[0].adr));
      chk("tid", 128'(o.tid), 128'(mq[0].tid));
      chk("cid", 128'(o.cid), 128'(mq[0].cid));
    end else begin
      chk("flags_idle", 128'({o.ack, o.err, o.rty}), 128'(0));
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input logic r, input logic a, input logic e, input logic y,
                      input logic [127:0] d, input logic rd);
    wb_read_response128_t nx;
    bit was_full;
    bit do_pop;
    nx     = '0;
    nx.ack = a;
    nx.err = e;
    nx.rty = y;
    nx.dat = d;
    nx.adr = $urandom;
    nx.tid = 8'($urandom);
    nx.cid = 4'($urandom);
    i      = nx;
    rst    = r;
    rdy    = rd;
    @(posedge clk);
    if (r) begin
      mq.delete();
      ovf_m = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = rd && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (a | e | y) begin
        if (!was_full || do_pop) mq.push_back(nx);
        else ovf_m = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic push_ack(input logic [127:0] d, input logic rd);
    step(1'b0, 1'b1, 1'b0, 1'b0, d, rd);
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 1'b0, 1'b0, 1'b0, 128'h0, rd);
  endtask

  initial begin
    logic [127:0] rd_dat;
    int  kind;
    i     = '0;
    rst   = 1'b1;
    rdy   = 1'b0;
    ovf_m = 1'b0;
    #2;

    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0);
    chk("rst_empty", 128'(empty), 128'(1));

    // Single push, then pop
    push_ack(128'h1, 1'b0);
    chk("single_ack", 128'(o.ack), 128'(1));
    idle(1'b0);
    idle(1'b1);
    chk("single_drained", 128'(empty), 128'(1));

    // Fill, overflow, drain
    for (int k = 0; k < 4; k++) push_ack(128'hA0 + 128'(k), 1'b0);
    chk("fill_afull", 128'(afull), 128'(1));
    push_ack(128'hE0, 1'b0);
    chk("fill_ovf", 128'(ovf), 128'(1));
    chk("fill_cnt", 128'(cnt), 128'(4));
    for (int k = 0; k < 5; k++) idle(1'b1);

    // Full with simultaneous push and pop
    step(1'b1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0);
    for (int k = 0; k < 4; k++) push_ack(128'hB0 + 128'(k), 1'b0);
    push_ack(128'hBE, 1'b1);
    chk("fullpp_ovf", 128'(ovf), 128'(0));
    chk("fullpp_cnt", 128'(cnt), 128'(4));
    for (int k = 0; k < 5; k++) idle(1'b1);

    // Streaming across pointer wrap
    for (int k = 1; k <= 10; k++) begin
      push_ack(128'(k), 1'b1);
      chk("stream_dat", o.dat, 128'(k));
    end
    idle(1'b1);

    // Error response
    step(1'b0, 1'b0, 1'b1, 1'b0, 128'hDEAD, 1'b0);
    chk("err_flag", 128'(o.err), 128'(1));
    idle(1'b1);

    // Mid-operation reset
    for (int k = 0; k < 5; k++) push_ack(128'hC0 + 128'(k), 1'b0);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0);
    chk("mrst_cnt", 128'(cnt), 128'(0));
    chk("mrst_ovf", 128'(ovf), 128'(0));
    push_ack(128'h5, 1'b0);
    chk("mrst_dat", o.dat, 128'h5);
    idle(1'b1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rd_dat = {$urandom, $urandom, $urandom, $urandom};
      kind   = int'($urandom_range(0, 9));
      if ($urandom_range(0, 79) == 0)
        step(1'b1, 1'b0, 1'b0, 1'b0, rd_dat, 1'b0);
      else
        step(1'b0, kind < 4, kind == 4, kind == 5, rd_dat, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
